// File: rtl/fir_fold_pkg.sv
// Shared widths, FSM encoding and saturation limits for the folded FIR MAC.
package fir_fold_pkg;

  localparam int unsigned DIN_W  = 16;
  localparam int unsigned COEF_W = 6;
  localparam int unsigned PROD_W = DIN_W + COEF_W;
  localparam int unsigned ACC_W  = 25;
  localparam int unsigned DOUT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  // Output clamp bound, expressed at the widened (ACC_W+1) rounding width.
  function automatic logic signed [ACC_W:0] sat_limit(input logic hi);
    logic signed [ACC_W:0] lim;
    if (hi) lim = (ACC_W + 1)'(2 ** (DOUT_W - 1) - 1);
    else    lim = -((ACC_W + 1)'(2 ** (DOUT_W - 1)));
    return lim;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift of the accumulator, then clamp to DOUT_W.
module fir_round_sat
  import fir_fold_pkg::*;
#(
  parameter int unsigned SHIFT = 5
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DOUT_W-1:0] dout
);

  localparam logic signed [ACC_W:0] Half = (ACC_W + 1)'(2 ** (SHIFT - 1));

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] hi_lim;
  logic signed [ACC_W:0] lo_lim;

  always_comb begin
    hi_lim  = sat_limit(1'b1);
    lo_lim  = sat_limit(1'b0);
    // One guard bit so adding the rounding constant can never wrap.
    biased  = $signed({acc[ACC_W-1], acc}) + Half;
    shifted = biased >>> SHIFT;
    dout    = shifted[DOUT_W-1:0];
    if (shifted > hi_lim)      dout = hi_lim[DOUT_W-1:0];
    else if (shifted < lo_lim) dout = lo_lim[DOUT_W-1:0];
  end

endmodule

// File: rtl/fir_fold_mac.sv
// Folded FIR: one shared multiplier walks NTAPS taps per accepted sample, then
// presents a rounded, saturated result on a valid/ready output.
module fir_fold_mac
  import fir_fold_pkg::*;
#(
  parameter int unsigned NTAPS = 8,
  parameter int unsigned SHIFT = 5
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [DIN_W-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic [DOUT_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned KW = $clog2(NTAPS);
  // k runs one past the last tap: that extra MAC cycle registers the result.
  localparam logic [KW:0] KDone = (KW + 1)'(NTAPS);

  state_e                    state_q;
  logic signed [DIN_W-1:0]   x_q [NTAPS];
  logic signed [COEF_W-1:0]  c_q [NTAPS];
  logic signed [ACC_W-1:0]   acc_q;
  logic [KW:0]               k_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [DOUT_W-1:0]         out_data_q;

  logic [KW-1:0]             tap;
  logic signed [PROD_W-1:0]  prod;
  logic signed [DOUT_W-1:0]  rounded;
  logic                      accept;
  logic                      coef_wr;

  always_comb begin
    tap     = k_q[KW-1:0];
    prod    = x_q[tap] * c_q[tap];
    accept  = (state_q == StIdle) && in_valid && in_ready_q;
    coef_wr = (state_q == StIdle) && coef_we && !accept;
  end

  fir_round_sat #(
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc  (acc_q),
    .dout (rounded)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            for (int i = NTAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
            x_q[0]     <= $signed(in_data);
            acc_q      <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StMac;
          end else if (coef_wr) begin
            c_q[coef_addr] <= $signed(coef_data);
          end
        end
        StMac: begin
          if (k_q == KDone) begin
            out_data_q  <= rounded;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            acc_q <= acc_q + ACC_W'(prod);
            k_q   <= k_q + (KW + 1)'(1);
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_fold_mac.sv
// Randomised and directed checks of fir_fold_mac against an arithmetic FIR model.
module tb_fir_fold_mac;

  localparam int NTAPS = 8;
  localparam int SHIFT = 5;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [5:0]  coef_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: sample history (newest first) and coefficient table.
  longint mx [NTAPS];
  longint mc [NTAPS];

  fir_fold_mac #(
    .NTAPS (NTAPS),
    .SHIFT (SHIFT)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
  endfunction

  // Push a sample and return the filter output it should produce.
  function automatic longint model_push(input longint x);
    longint acc;
    longint r;
    for (int i = NTAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = x;
    acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += mx[i] * mc[i];
    r = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic write_coef(input int addr, input int val);
    @(negedge ap_clk);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 6'(val);
    mc[addr]  = val;
    @(negedge ap_clk);
    coef_we   = 1'b0;
  endtask

  // Send one sample; optionally collide a coefficient write with the accept,
  // and optionally hold out_ready low for 'hold' cycles while poking inputs.
  task automatic send_sample(input int x, input int hold, input bit collide);
    int     waitc;
    int     lat;
    longint exp;
    logic [15:0] held;
    waitc = 0;
    @(negedge ap_clk);
    while (!in_ready && waitc < 30) begin
      @(negedge ap_clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_wait", 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_data   = 16'(x);
    out_ready = (hold == 0);
    if (collide) begin
      coef_we   = 1'b1;
      coef_addr = 3'($urandom_range(0, NTAPS - 1));
      coef_data = 6'($urandom_range(0, 63));
    end
    exp = model_push(x);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge ap_clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", lat, NTAPS + 1);
    check("out_data", $signed(out_data), exp);
    if (hold > 0) begin
      held = out_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge ap_clk);
        check("bp_valid", out_valid, 1);
        check("bp_stable", out_data, held);
        check("bp_in_ready", in_ready, 0);
        in_valid  = ~in_valid;
        in_data   = 16'($urandom);
        coef_we   = ~coef_we;
        coef_addr = 3'($urandom_range(0, NTAPS - 1));
        coef_data = 6'($urandom_range(0, 63));
      end
      @(negedge ap_clk);
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      out_ready = 1'b1;
      check("bp_hold_end", out_data, held);
    end
    @(posedge ap_clk);
    #1;
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    model_clear();

    // Reset behaviour
    repeat (5) @(negedge ap_clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    ap_rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(posedge ap_clk);
    #1;
    check("rel_in_ready_high", in_ready, 1);

    // Impulse through coefficients 1..8, plus one trailing zero
    for (int i = 0; i < NTAPS; i++) write_coef(i, i + 1);
    send_sample(32, 0, 1'b0);
    for (int i = 0; i < NTAPS; i++) send_sample(0, 0, 1'b0);

    // Saturation
    for (int i = 0; i < NTAPS; i++) write_coef(i, 31);
    for (int i = 0; i < NTAPS; i++) send_sample(32767, 0, 1'b0);
    for (int i = 0; i < NTAPS; i++) write_coef(i, -32);
    for (int i = 0; i < NTAPS; i++) send_sample(32767, 0, 1'b0);
    for (int i = 0; i < NTAPS; i++) send_sample(-32768, 0, 1'b0);

    // Rounding at the half-LSB boundary
    write_coef(0, 1);
    for (int i = 1; i < NTAPS; i++) write_coef(i, 0);
    send_sample(16, 0, 1'b0);
    send_sample(15, 0, 1'b0);
    send_sample(-16, 0, 1'b0);
    send_sample(-17, 0, 1'b0);

    // Back-pressure, then prove nothing leaked in via follow-up samples
    for (int i = 0; i < NTAPS; i++) write_coef(i, i - 3);
    send_sample(1000, 10, 1'b0);
    for (int i = 0; i < 4; i++) send_sample(int'($urandom_range(0, 65535)) - 32768, 0, 1'b0);

    // Random coefficients and samples, some with colliding (dropped) writes
    for (int n = 0; n < 16; n++) begin
      write_coef(int'($urandom_range(0, NTAPS - 1)), int'($urandom_range(0, 63)) - 32);
      send_sample(int'($urandom_range(0, 65535)) - 32768, 0, ($urandom_range(0, 3) == 0));
    end

    // Reset during MAC cycle 3 must swallow the result
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = 16'd32;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_valid", out_valid, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);

    for (int i = 0; i < NTAPS; i++) write_coef(i, i + 1);
    send_sample(32, 0, 1'b0);
    for (int i = 0; i < NTAPS; i++) send_sample(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
